// File: rtl/md_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit.
// Optional single-cycle multiply is enabled by MD_FAST_MULT_EN.
package md_pkg;

  localparam logic [2:0] MD_OP_NOP   = 3'd0;
  localparam logic [2:0] MD_OP_MULT  = 3'd1;
  localparam logic [2:0] MD_OP_MULTU = 3'd2;
  localparam logic [2:0] MD_OP_DIV   = 3'd3;
  localparam logic [2:0] MD_OP_DIVU  = 3'd4;
  localparam logic [2:0] MD_OP_MTHI  = 3'd5;
  localparam logic [2:0] MD_OP_MTLO  = 3'd6;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_RUN  = 2'd1;
  localparam logic [1:0] MD_ST_FIX  = 2'd2;

  localparam int MD_CNT_W = 6;

  function automatic logic [31:0] md_abs(
    input logic [31:0] v,
    input logic        sgn
  );
    return (sgn && v[31]) ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/md_iter_core.sv
// 32-step shift-add multiplier / restoring divider.
// Exposes raw unsigned {hi,lo}; signs are handled by the caller.
module md_iter_core
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        step_i,
  input  logic        is_div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic [31:0] rem_q;
  logic [31:0] lo_q;
  logic [31:0] opb_q;
  logic        div_q;

  logic [32:0] sum;
  logic [32:0] sh;
  logic [32:0] diff;

  always_comb begin
    sum  = {1'b0, rem_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    sh   = {rem_q, lo_q[31]};
    diff = sh - {1'b0, opb_q};
  end

  // lo_q holds the multiplier (mult) or the dividend/quotient (div)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      rem_q <= '0;
      lo_q  <= is_div_i ? a_i : b_i;
      opb_q <= is_div_i ? b_i : a_i;
      div_q <= is_div_i;
    end else if (step_i) begin
      if (div_q) begin
        if (diff[32]) begin
          rem_q <= sh[31:0];
          lo_q  <= {lo_q[30:0], 1'b0};
        end else begin
          rem_q <= diff[31:0];
          lo_q  <= {lo_q[30:0], 1'b1};
        end
      end else begin
        rem_q <= sum[32:1];
        lo_q  <= {sum[0], lo_q[31:1]};
      end
    end
  end

  assign res_o = {rem_q, lo_q};

endmodule

// File: rtl/hilo_md_unit.sv
// HI/LO registers with multi-cycle mult/div; FSM, sign fix, flush.
// MD_FAST_MULT_EN selects a single-cycle multiply path.
module hilo_md_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [1:0]          st_q, st_d;
  logic [MD_CNT_W-1:0] cnt_q;
  logic [31:0]         hi_q, lo_q;
  logic                done_q;
  logic                neg_q, rneg_q, div_q;

  logic        is_md, is_div, sgn, fast_d, load;
  logic [31:0] a_abs, b_abs;
  logic [63:0] core_res, raw, prod;
  logic [31:0] fix_hi, fix_lo;

  always_comb begin
    is_md  = 1'b0;
    is_div = 1'b0;
    sgn    = 1'b0;
    unique case (1'b1)
      op == MD_OP_MULT:  begin is_md = 1'b1; sgn = 1'b1; end
      op == MD_OP_MULTU: is_md = 1'b1;
      op == MD_OP_DIV:   begin is_md = 1'b1; is_div = 1'b1; sgn = 1'b1; end
      op == MD_OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; end
      default: ;
    endcase
  end

  assign a_abs = md_abs(a, sgn);
  assign b_abs = md_abs(b, sgn);

`ifdef MD_FAST_MULT_EN
  logic        fast_q;
  logic [63:0] fprod_q;
  assign fast_d = ~is_div;
  assign raw    = fast_q ? fprod_q : core_res;
`else
  assign fast_d = 1'b0;
  assign raw    = core_res;
`endif

  assign load = (st_q == MD_ST_IDLE) && start && is_md && !fast_d;

  always_comb begin
    st_d = st_q;
    case (st_q)
      MD_ST_IDLE:
        if (start && is_md) st_d = fast_d ? MD_ST_FIX : MD_ST_RUN;
      MD_ST_RUN:
        if (flush) st_d = MD_ST_IDLE;
        else if (cnt_q == MD_CNT_W'(31)) st_d = MD_ST_FIX;
      MD_ST_FIX:
        st_d = MD_ST_IDLE;
      default:
        st_d = MD_ST_IDLE;
    endcase
  end

  md_iter_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (load),
    .step_i   (st_q == MD_ST_RUN),
    .is_div_i (is_div),
    .a_i      (a_abs),
    .b_i      (b_abs),
    .res_o    (core_res)
  );

  // Quotient sign is neg_q, remainder follows the dividend (rneg_q)
  always_comb begin
    prod = neg_q ? (64'd0 - raw) : raw;
    if (div_q) begin
      fix_lo = neg_q  ? (32'd0 - raw[31:0])  : raw[31:0];
      fix_hi = rneg_q ? (32'd0 - raw[63:32]) : raw[63:32];
    end else begin
      fix_lo = prod[31:0];
      fix_hi = prod[63:32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= MD_ST_IDLE;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      done_q <= 1'b0;
      if (st_q == MD_ST_IDLE && start) begin
        if (op == MD_OP_MTHI) hi_q <= a;
        if (op == MD_OP_MTLO) lo_q <= a;
        if (is_md) begin
          neg_q  <= sgn & (a[31] ^ b[31]);
          rneg_q <= sgn & a[31];
          div_q  <= is_div;
          cnt_q  <= '0;
        end
      end
      if (st_q == MD_ST_RUN) cnt_q <= cnt_q + 1'b1;
      if (st_q == MD_ST_FIX && !flush) begin
        hi_q   <= fix_hi;
        lo_q   <= fix_lo;
        done_q <= 1'b1;
      end
    end
  end

`ifdef MD_FAST_MULT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fast_q  <= 1'b0;
      fprod_q <= '0;
    end else if (st_q == MD_ST_IDLE && start && is_md) begin
      fast_q  <= fast_d;
      fprod_q <= a_abs * b_abs;
    end
  end
`endif

  assign busy = (st_q != MD_ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Directed self-checking bench for hilo_md_unit.
// Expected mult busy length follows MD_FAST_MULT_EN.
module tb_hilo_md_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

`ifdef MD_FAST_MULT_EN
  localparam int MULT_CYC = 1;
`else
  localparam int MULT_CYC = 33;
`endif
  localparam int DIV_CYC = 33;

  always #5 clk = ~clk;

  hilo_md_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic issue(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 3'd0; a = '0; b = '0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks += 4;
    if (hi !== 32'd0) begin errors++; $display("FAIL rst_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL rst_lo got %h want 0", lo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
  endtask

  task automatic test_op(input string nm, input logic [2:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ehi, input logic [31:0] elo,
                         input int ecyc);
    int n;
    @(negedge clk);
    issue(o, x, y);
    wait_idle(n);
    checks += 5;
    if (n != ecyc) begin errors++; $display("FAIL %s_busy got %0d want %0d", nm, n, ecyc); end
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done got %b want 1", nm, done); end
    if (hi !== ehi) begin errors++; $display("FAIL %s_hi got %h want %h", nm, hi, ehi); end
    if (lo !== elo) begin errors++; $display("FAIL %s_lo got %h want %h", nm, lo, elo); end
    @(negedge clk);
    if (done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %b want 0", nm, done); end
  endtask

  task automatic test_mthi_ignore();
    int n;
    @(negedge clk);
    issue(3'd5, 32'h1234_5678, 32'h0);
    checks += 2;
    if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h want 12345678", hi); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b want 0", busy); end
    issue(3'd6, 32'hCAFE_0001, 32'h0);
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    issue(3'd1, 32'd9, 32'd9);
    issue(3'd5, 32'hDEAD_BEEF, 32'h0);
    issue(3'd6, 32'hDEAD_BEEF, 32'h0);
    checks += 2;
    if (hi !== 32'h1234_5678) begin errors++; $display("FAIL ign_hi got %h want 12345678", hi); end
    if (lo !== 32'hCAFE_0001) begin errors++; $display("FAIL ign_lo got %h want cafe0001", lo); end
    wait_idle(n);
    checks += 3;
    if (n != DIV_CYC - 6) begin errors++; $display("FAIL ign_busy got %0d want %0d", n, DIV_CYC - 6); end
    if (hi !== 32'd2) begin errors++; $display("FAIL ign_res_hi got %h want 2", hi); end
    if (lo !== 32'd14) begin errors++; $display("FAIL ign_res_lo got %h want e", lo); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks += 4;
    if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", busy); end
    if (hi !== 32'd2) begin errors++; $display("FAIL flush_hi got %h want 2", hi); end
    if (lo !== 32'd14) begin errors++; $display("FAIL flush_lo got %h want e", lo); end
    if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b want 0", done); end
    repeat (30) @(negedge clk);
    checks += 2;
    if (done !== 1'b0) begin errors++; $display("FAIL flush_late_done got %b want 0", done); end
    if (lo !== 32'd14) begin errors++; $display("FAIL flush_late_lo got %h want e", lo); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue(3'd4, 32'd1000, 32'd3);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks += 3;
    if (hi !== 32'd0) begin errors++; $display("FAIL arst_hi got %h want 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL arst_lo got %h want 0", lo); end
    if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    issue(3'd2, 32'd3, 32'd4);
    wait_idle(n);
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
    if (lo !== 32'd12) begin errors++; $display("FAIL b2b_lo1 got %h want c", lo); end
    issue(3'd4, 32'd12, 32'd5);
    checks += 1;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got %b want 1", busy); end
    wait_idle(n);
    checks += 3;
    if (n != DIV_CYC) begin errors++; $display("FAIL b2b_cyc got %0d want %0d", n, DIV_CYC); end
    if (hi !== 32'd2) begin errors++; $display("FAIL b2b_hi got %h want 2", hi); end
    if (lo !== 32'd2) begin errors++; $display("FAIL b2b_lo got %h want 2", lo); end
  endtask

  initial begin
    #1;
    test_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    test_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3,
            32'hFFFF_FFFF, 32'hFFFF_FFFA, MULT_CYC);
    test_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFE, 32'h0000_0001, MULT_CYC);
    test_op("mult_2_16", 3'd1, 32'h0001_0000, 32'h0001_0000,
            32'h0000_0001, 32'h0000_0000, MULT_CYC);
    test_op("mult_pp", 3'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB,
            32'h0000_0000, 32'h0000_000F, MULT_CYC);
    test_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2,
            32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC);
    test_op("divu_zero", 3'd4, 32'd7, 32'd0,
            32'h0000_0007, 32'hFFFF_FFFF, DIV_CYC);
    test_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF,
            32'h0000_0000, 32'h8000_0000, DIV_CYC);
    test_op("divu_big", 3'd4, 32'hFFFF_FFFF, 32'h0001_0000,
            32'h0000_FFFF, 32'h0000_FFFF, DIV_CYC);
    test_op("div_zero_s", 3'd3, 32'hFFFF_FFF9, 32'd0,
            32'hFFFF_FFF9, 32'h0000_0001, DIV_CYC);
    test_mthi_ignore();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Multi-cycle multiply/divide unit plus the architectural HI/LO register pair for the MIPS pipeline. It is the write-side consumer of the EX-stage HI select: it accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX, runs an iterative 32-step datapath, and commits the result to HI/LO. The pipeline stalls on `busy`, and MFHI/MFLO read `hi`/`lo` directly.

## Interface
- No parameters; data width is fixed at 32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request qualifier; ignored while `busy`.
- `op`  in  3  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; codes 7 and 0 are treated as NOP.
- `a`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `b`  in  32  rt operand: multiplier or divisor.
- `flush`  in  1  abort an in-flight operation (exception/eret).
- `busy`  out  1  operation in flight; the pipeline must stall MFHI/MFLO and new mult/div.
- `done`  out  1  one-cycle pulse on the cycle after HI/LO commit.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - `start` with MTHI writes `a`→`hi`; MTLO writes `a`→`lo`. Both take effect at the next edge and do not assert `busy`.
  - `start` with MULT/MULTU/DIV/DIVU latches the absolute values of the operands (signed ops) or the raw operands (unsigned ops). It also latches the result signs, clears the step count, and enters RUN.
- RUN: one step per cycle for 32 cycles, then FIX.
  - Multiply: shift-add on a 64-bit accumulator.
  - Divide: restoring division; 33-bit partial remainder, one quotient bit per step.
- FIX: apply signs, write `hi`/`lo`, set `done`, return to IDLE.
- Signed multiply: the 64-bit product is negated if sign(a) ≠ sign(b). HI takes bits 63:32 and LO takes bits 31:0.
- Signed divide:
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a). LO = quotient, HI = remainder.
  - 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- Divide by zero (either signedness): LO = 0xFFFFFFFF, HI = `a`, unsigned-interpreted before sign fix. The signed result is still sign-fixed; no trap is raised.
- `flush` in RUN or FIX: return to IDLE at the next edge. `hi`/`lo` are unchanged and `done` stays low. `flush` has priority over `start` and over the FIX commit.
- `start` while `busy`: ignored, with no side effects.
- Reset (asynchronous, any state, including mid-operation): `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, state IDLE, internal accumulators 0.

## Timing
- Mult/div `start` is sampled at edge N.
  - `busy` is high from just after edge N until just after edge N+33.
  - `hi`/`lo` take the new values at edge N+33.
  - `done` is high for the cycle between edges N+33 and N+34.
- Total latency: 33 cycles from accept to commit.
- MTHI/MTLO sampled at edge N are visible on `hi`/`lo` after edge N.
- `busy` = (state ≠ IDLE) is decoded from registered state; there is no combinational path from `start` to `busy`.
- Back-to-back: a new `start` is accepted in the cycle `done` is high.

## Configuration
- `MD_FAST_MULT_EN` defined:
  - MULT/MULTU use a single-cycle `*` product and skip RUN, going IDLE→FIX.
  - `hi`/`lo` update at edge N+1, `busy` is high for one cycle, and `done` is pulsed after edge N+1.
  - Divide timing is unchanged.
- `MD_FAST_MULT_EN` undefined: all four ops use the 33-cycle iterative path.

## Structure
- Shared package `md_pkg` holds the op encoding constants (`MD_OP_*`), the state encoding (IDLE/RUN/FIX), and the step-count width (6).
- One sub-module, `md_iter_core`, contains the 32-step shift-add/restoring datapath. It has a load/step interface and exposes raw 64-bit `{hi,lo}`.
- The top level owns the FSM, sign handling, the HI/LO registers, and the flush logic.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3 → at edge N+33, `hi`=0xFFFFFFFF and `lo`=0xFFFFFFFA; `done` pulses once; `busy` is high for 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- DIV a=−7 (0xFFFFFFF9), b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=0 → `lo`=0xFFFFFFFF, `hi`=7.
- MTHI a=0x12345678, then a MULT `start` while `busy` with different operands → `hi`=0x12345678 after one edge. The second `start` is ignored, and the first result commits unchanged.
- DIV started, `flush` at step 10 → `busy` drops after the next edge, `hi`/`lo` keep their prior values, and `done` stays 0. `rst_n` low at step 20 of a new op → `hi`=`lo`=0 immediately.
- With `MD_FAST_MULT_EN`, MULT 0x00010000 × 0x00010000 → after edge N+1, `hi`=1 and `lo`=0, with one `busy` cycle.
